// File: rtl/fpu_big_alu_seq.sv
// fpu_big_alu_seq: multi-cycle sliced sign-magnitude add/subtract with negate pass
module fpu_big_alu_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic             a_sign,
  input  logic [WIDTH-1:0] b,
  input  logic             b_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   extended_result,
  output logic             result_sign,
  output logic             result_zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, SUM, NEG, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, low_nxt;
  logic [WIDTH:0] res;
  logic [IW-1:0] idx;
  logic [31:0] base;
  logic [CHUNK:0] sum, neg;
  logic eff_sub, carry, sign_r, zero_r, valid_r, last, fin_zero, underflow;
  assign in_ready = state == IDLE;
  assign out_valid = valid_r;
  assign extended_result = res;
  assign result_sign = sign_r;
  assign result_zero = zero_r;
  // slice arithmetic for the current index: add/sub slice, negate slice, and the merged magnitude
  always_comb begin
    base = 32'(idx) * 32'(CHUNK);
    last = idx == IW'(N - 1);
    sum = {1'b0, a_r[base+:CHUNK]} + {1'b0, eff_sub ? ~b_r[base+:CHUNK] : b_r[base+:CHUNK]} + {{CHUNK{1'b0}}, carry};
    neg = {1'b0, ~res[base+:CHUNK]} + {{CHUNK{1'b0}}, carry};
    low_nxt = res[WIDTH-1:0];
    low_nxt[base+:CHUNK] = state == NEG ? neg[CHUNK-1:0] : sum[CHUNK-1:0];
    underflow = eff_sub && !sum[CHUNK];
    fin_zero = low_nxt == '0 && (eff_sub || !sum[CHUNK]);
  end
  // next-state: one pass over the slices, optional negate pass, hold until consumed
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = in_valid ? SUM : IDLE;
      SUM:  state_nxt = last ? (underflow ? NEG : DONE) : SUM;
      NEG:  state_nxt = last ? DONE : NEG;
      DONE: state_nxt = out_ready ? IDLE : DONE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // datapath: operand capture, slice accumulation, sign/zero resolution on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      res <= '0;
      idx <= '0;
      eff_sub <= 1'b0;
      carry <= 1'b0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          eff_sub <= a_sign ^ b_sign ^ op;
          carry <= a_sign ^ b_sign ^ op;
          sign_r <= a_sign;
          idx <= '0;
        end
        SUM: begin
          res <= {last ? (~eff_sub & sum[CHUNK]) : res[WIDTH], low_nxt};
          carry <= sum[CHUNK];
          idx <= last ? '0 : idx + 1'b1;
          if (last && underflow) begin
            sign_r <= ~sign_r;
            carry <= 1'b1;
          end else if (last) begin
            valid_r <= 1'b1;
            zero_r <= fin_zero;
            if (fin_zero) sign_r <= 1'b0;
          end
        end
        NEG: begin
          res <= {1'b0, low_nxt};
          carry <= neg[CHUNK];
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            valid_r <= 1'b1;
            zero_r <= fin_zero;
            if (fin_zero) sign_r <= 1'b0;
          end
        end
        DONE: if (out_ready) valid_r <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_big_alu_seq.sv
// tb_fpu_big_alu_seq: directed and random checks against a signed-arithmetic reference
module tb_fpu_big_alu_seq;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int N = WIDTH / CHUNK;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, op = 1'b0, a_sign = 1'b0, b_sign = 1'b0, out_ready = 1'b1;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic in_ready, out_valid, result_sign, result_zero;
  logic [WIDTH:0] extended_result;
  int n_vec = 0, n_fail = 0, n_chk = 0;
  logic [WIDTH:0] e_mag;
  logic e_sign;
  int e_lat;

  fpu_big_alu_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .a_sign(a_sign), .b(b), .b_sign(b_sign), .out_valid(out_valid),
    .out_ready(out_ready), .extended_result(extended_result),
    .result_sign(result_sign), .result_zero(result_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: true signed arithmetic, magnitude/sign split; a negate pass is
  // needed exactly when a nonzero result's sign differs from a's sign
  task automatic model(input logic [WIDTH-1:0] ma, input logic mas, input logic [WIDTH-1:0] mb,
                       input logic mbs, input logic mop);
    logic signed [WIDTH+3:0] ai, bi, r;
    ai = mas ? -$signed({4'b0, ma}) : $signed({4'b0, ma});
    bi = mbs ? -$signed({4'b0, mb}) : $signed({4'b0, mb});
    r = mop ? ai - bi : ai + bi;
    e_sign = r < 0;
    r = e_sign ? -r : r;
    e_mag = r[WIDTH:0];
    e_lat = (r != 0 && e_sign != mas) ? 2 * N : N;
  endtask

  task automatic drive(input logic [WIDTH-1:0] ma, input logic mas, input logic [WIDTH-1:0] mb,
                       input logic mbs, input logic mop);
    a = ma; a_sign = mas; b = mb; b_sign = mbs; op = mop;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] ma, input logic mas, input logic [WIDTH-1:0] mb,
                       input logic mbs, input logic mop);
    model(ma, mas, mb, mbs, mop);
    drive(ma, mas, mb, mbs, mop);
    chk("in_ready_idle", {{WIDTH{1'b0}}, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
  endtask

  task automatic wait_check(input string tag);
    int cnt = 0;
    while (!out_valid && cnt < 40) begin
      chk({tag, "_busy"}, {{WIDTH{1'b0}}, in_ready}, 0);
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_lat"}, (WIDTH+1)'(cnt), (WIDTH+1)'(e_lat));
    chk({tag, "_valid"}, {{WIDTH{1'b0}}, out_valid}, 1);
    chk({tag, "_mag"}, extended_result, e_mag);
    chk({tag, "_sign"}, {{WIDTH{1'b0}}, result_sign}, {{WIDTH{1'b0}}, e_sign});
    chk({tag, "_zero"}, {{WIDTH{1'b0}}, result_zero}, {{WIDTH{1'b0}}, e_mag == 0});
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] ma, input logic mas,
                       input logic [WIDTH-1:0] mb, input logic mbs, input logic mop);
    issue(ma, mas, mb, mbs, mop);
    wait_check(tag);
    @(negedge clk);
    chk({tag, "_release"}, {{WIDTH{1'b0}}, out_valid}, 0);
    chk({tag, "_idle"}, {{WIDTH{1'b0}}, in_ready}, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", {{WIDTH{1'b0}}, out_valid}, 0);
    chk("rst_result", extended_result, 0);
    chk("rst_sign", {{WIDTH{1'b0}}, result_sign}, 0);
    chk("rst_zero", {{WIDTH{1'b0}}, result_zero}, 0);
    chk("rst_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    rst = 1'b0;
    @(negedge clk);
    do_op("carry", 64'hFFFF, 1'b0, 64'h1, 1'b0, 1'b0);
    chk("carry_const", extended_result, 65'h1_0000);
    do_op("neg", 64'd5, 1'b0, 64'd9, 1'b0, 1'b1);
    chk("neg_const", extended_result, 65'd4);
    do_op("mixed", 64'd5, 1'b1, 64'd9, 1'b0, 1'b0);
    do_op("ovf", '1, 1'b0, '1, 1'b0, 1'b0);
    chk("ovf_const", extended_result, 65'h1_FFFF_FFFF_FFFF_FFFE);
    do_op("negzero", 64'd7, 1'b1, 64'd7, 1'b1, 1'b1);
    chk("negzero_const", {{WIDTH{1'b0}}, result_zero}, 1);
    // backpressure with a pending operand bundle
    out_ready = 1'b0;
    issue(64'd100, 1'b0, 64'd23, 1'b0, 1'b0);
    wait_check("bp");
    drive(64'd8, 1'b0, 64'd20, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {{WIDTH{1'b0}}, out_valid}, 1);
      chk("bp_hold_mag", extended_result, 65'd123);
      chk("bp_hold_ready", {{WIDTH{1'b0}}, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {{WIDTH{1'b0}}, out_valid}, 0);
    chk("bp_idle", {{WIDTH{1'b0}}, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_taken", {{WIDTH{1'b0}}, in_ready}, 0);
    model(64'd8, 1'b0, 64'd20, 1'b0, 1'b1);
    n_vec++;
    wait_check("bp_pend");
    @(negedge clk);
    // reset in the middle of the first pass
    issue(64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", {{WIDTH{1'b0}}, out_valid}, 0);
    chk("abort_result", extended_result, 0);
    chk("abort_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 64'd3, 1'b0, 64'd4, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      int mode;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      if (mode == 1) rb = ra;
      if (mode == 2) begin ra = ra & 64'hF; rb = rb & 64'hF; end
      if (mode == 3) rb = ra ^ {48'd0, 16'($urandom)};
      do_op("rand", ra, 1'($urandom), rb, 1'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
